clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode sequencer for the digital clock. Decodes debounced front-panel buttons into the `clk_mode` that drives the time-formatting stage, and owns the 12/24-hour format register and the alarm-time register. In its set modes it holds an editable BCD time image. It issues a one-cycle load strobe to the timekeeping counter. It sits between the button debouncers and the timekeeper / time-formatting / display path.

## Interface
Parameters:
- `BLINK_DIV`, 25_000_000: cycles per `blink` half-period in set modes.
- `TIMEOUT_CYC`, 500_000_000: idle cycles in a set mode before abort to RUN.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_mode`  in  1  debounced level; rising edge advances mode.
- `btn_next`  in  1  debounced level; rising edge selects next field.
- `btn_inc`  in  1  debounced level; rising edge increments selected field.
- `btn_fmt`  in  1  debounced level; rising edge toggles 12/24-hour format.
- `btn_alen`  in  1  debounced level; rising edge toggles alarm enable.
- `clock_time`  in  24  live BCD time {HH,MM,SS}.
- `clk_mode`  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM.
- `setampm`  out  1  format: 1 = 24-hour, 0 = 12-hour.
- `edit_time`  out  24  BCD image being edited; 0 in RUN.
- `field_sel`  out  2  00 HH, 01 MM, 10 SS.
- `time_load`  out  1  one-cycle strobe; timekeeper loads `edit_time`.
- `alarm_time`  out  24  stored alarm, BCD {HH,MM,00}.
- `alarm_en`  out  1  alarm armed.
- `blink`  out  1  display blink for the selected field; 0 in RUN.

## Operation
- Edge detect: `edge_x = btn_x & ~prev_x`. `prev_x` registers reset to 1, so a button held through reset does not fire.
- Per-cycle action priority: mode > next > inc. Lower-priority edges in the same cycle are dropped. `btn_fmt` and `btn_alen` are independent of this priority.
- FSM:
  - RUN, mode edge → SET_TIME: `edit_time` ← `clock_time`, `field_sel` ← HH.
  - SET_TIME:
    - next edge: HH→MM→SS→HH.
    - inc edge: increment the selected field in BCD. HH wraps 23→00; MM and SS wrap 59→00. Other fields are unchanged; no carry between fields.
    - mode edge: `time_load` = 1 for one cycle with `edit_time` still valid. Then → SET_ALARM, `edit_time` ← `alarm_time`, `field_sel` ← HH.
  - SET_ALARM:
    - next edge: HH↔MM only.
    - inc edge: same increment rules as SET_TIME.
    - mode edge: `alarm_time` ← {edit HH, edit MM, 8'h00}, → RUN.
- Timeout:
  - Idle counter clears on any btn_mode/next/inc edge and on state entry.
  - When it reaches `TIMEOUT_CYC` in a set mode → RUN.
  - No `time_load` and no alarm write on timeout.
- `setampm` toggles on a `btn_fmt` edge in any state.
- `alarm_en` toggles on a `btn_alen` edge in RUN only; the edge is ignored in set modes.
- `blink`: counter toggles `blink` every `BLINK_DIV` cycles in set modes. It is forced to 0 with the counter cleared in RUN, and restarts at 1 on each set-mode entry.
- Edit values are always valid BCD; inc from an invalid captured digit wraps to 00.

## Timing
- All outputs are registered.
- A button first sampled high in cycle n has its effect visible on outputs in cycle n+1.
- In SET_TIME, `time_load` is high in cycle n+1 only. In that same cycle `clk_mode` = 01 and `edit_time` holds the committed value. In cycle n+2 `clk_mode` = 10.
- Reset values:
  - `clk_mode` = 00, `setampm` = 0, `edit_time` = 0, `field_sel` = 00.
  - `time_load` = 0, `alarm_time` = 24'h000000, `alarm_en` = 0, `blink` = 0.
  - Counters = 0, `prev_x` = 1.
- Reset mid-edit: the edit is discarded, no load is issued, and the stored alarm is cleared.
- `rst` has priority over every other event in the same cycle.

## Structure
- Shared package `clock_pkg`:
  - mode constants MODE_RUN/MODE_SET_TIME/MODE_SET_ALARM (2'b00/01/10).
  - field constants FLD_HH/FLD_MM/FLD_SS.
  - BCD limit constants 8'h23 and 8'h59.
- Sub-module `bcd_field_inc`: combinational. Takes 8-bit BCD plus a max value and returns the incremented, wrapped BCD value.
- Counter widths: `$clog2(BLINK_DIV+1)` and `$clog2(TIMEOUT_CYC+1)`.

## Test plan
- Reset with `btn_mode` held high, then keep it high → `clk_mode` stays 00, no spurious transition.
- `clock_time` = 24'h235958, mode edge, inc ×1 → `edit_time` = 24'h005958. Then next, inc → 24'h000058. Then next, inc → 24'h000059.
- Continue with a mode edge → `time_load` high exactly one cycle with `edit_time` = 24'h000059, `clk_mode` = 10 next cycle.
- SET_ALARM: inc ×7 on HH, next, inc ×30, mode edge → `alarm_time` = 24'h073000, `clk_mode` = 00. `btn_alen` edge → `alarm_en` = 1.
- mode, next, inc rising in the same cycle in SET_TIME → mode taken, field and value unchanged. `btn_fmt` edge in any mode → `setampm` toggles 0→1.
- With TIMEOUT_CYC = 20, BLINK_DIV = 4: enter SET_TIME and idle → `blink` toggles every 4 cycles, return to RUN at cycle 20, `time_load` never asserted.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock mode sequencer: output mode codes,
// field selectors, BCD wrap limits and the internal sequencer state type.
package clock_pkg;

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;

    localparam logic [1:0] FLD_HH = 2'b00;
    localparam logic [1:0] FLD_MM = 2'b01;
    localparam logic [1:0] FLD_SS = 2'b10;

    localparam logic [7:0] BCD_MAX_HH = 8'h23;
    localparam logic [7:0] BCD_MAX_MS = 8'h59;

    // ST_LOAD is the single cycle that presents time_load while clk_mode still reads SET_TIME
    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_TIME,
        ST_LOAD,
        ST_SET_ALARM
    } state_t;

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational two-digit BCD increment with wrap to 00 at a BCD maximum;
// any invalid digit or out-of-range value also wraps to 00.
module bcd_field_inc (
    input  logic [7:0] i_val,
    input  logic [7:0] i_max,
    output logic [7:0] o_val
);

    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = i_val[7:4];
    assign w_lo = i_val[3:0];

    // Valid BCD orders the same as binary, so the range test is a plain compare
    always_comb begin
        if (w_hi > 4'd9 || w_lo > 4'd9 || i_val >= i_max)
            o_val = '0;
        else if (w_lo == 4'd9)
            o_val = {w_hi + 4'd1, 4'd0};
        else
            o_val = {w_hi, w_lo + 4'd1};
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode sequencer: RUN / SET_TIME / SET_ALARM, field editing,
// timekeeper load strobe, alarm register, 12/24h format and blink generation.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_fmt,
    input  logic        btn_alen,
    input  logic [23:0] clock_time,
    output logic [1:0]  clk_mode,
    output logic        setampm,
    output logic [23:0] edit_time,
    output logic [1:0]  field_sel,
    output logic        time_load,
    output logic [23:0] alarm_time,
    output logic        alarm_en,
    output logic        blink
);

    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

    state_t        r_state, w_state_nxt;
    logic [4:0]    r_prev;
    logic          r_setampm, w_setampm_nxt;
    logic [23:0]   r_edit, w_edit_nxt;
    logic [1:0]    r_field, w_field_nxt;
    logic          r_time_load, w_tload_nxt;
    logic [23:0]   r_alarm, w_alarm_nxt;
    logic          r_alarm_en, w_alen_nxt;
    logic          r_blink, w_blink_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic [TW-1:0] r_idle, w_idle_nxt, w_idle_inc;
    logic          w_enter_set;

    logic w_e_mode, w_e_next, w_e_inc, w_e_fmt, w_e_alen;
    logic [7:0] w_fld_val, w_fld_max, w_inc_val;

    assign w_e_mode = btn_mode & ~r_prev[4];
    assign w_e_next = btn_next & ~r_prev[3];
    assign w_e_inc  = btn_inc  & ~r_prev[2];
    assign w_e_fmt  = btn_fmt  & ~r_prev[1];
    assign w_e_alen = btn_alen & ~r_prev[0];

    assign w_fld_val = (r_field == FLD_HH) ? r_edit[23:16] :
                       (r_field == FLD_MM) ? r_edit[15:8]  : r_edit[7:0];
    assign w_fld_max = (r_field == FLD_HH) ? BCD_MAX_HH : BCD_MAX_MS;
    assign w_idle_inc = r_idle + TW'(1);

    bcd_field_inc u_inc (
        .i_val (w_fld_val),
        .i_max (w_fld_max),
        .o_val (w_inc_val)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_edit_nxt    = r_edit;
        w_field_nxt   = r_field;
        w_alarm_nxt   = r_alarm;
        w_alen_nxt    = r_alarm_en;
        w_tload_nxt   = 1'b0;
        w_idle_nxt    = '0;
        w_enter_set   = 1'b0;
        w_setampm_nxt = r_setampm ^ w_e_fmt;
        w_blink_nxt   = r_blink;
        w_bcnt_nxt    = r_bcnt;

        case (r_state)
            ST_RUN: begin
                w_alen_nxt  = r_alarm_en ^ w_e_alen;
                w_edit_nxt  = '0;
                w_field_nxt = FLD_HH;
                if (w_e_mode) begin
                    w_state_nxt = ST_SET_TIME;
                    w_edit_nxt  = clock_time;
                    w_enter_set = 1'b1;
                end
            end
            // Button edges arriving during the load cycle are deliberately dropped
            ST_LOAD: begin
                w_state_nxt = ST_SET_ALARM;
                w_edit_nxt  = r_alarm;
                w_field_nxt = FLD_HH;
                w_enter_set = 1'b1;
            end
            default: begin
                if (w_e_mode) begin
                    if (r_state == ST_SET_TIME) begin
                        w_state_nxt = ST_LOAD;
                        w_tload_nxt = 1'b1;
                    end else begin
                        w_alarm_nxt = {r_edit[23:8], 8'h00};
                        w_state_nxt = ST_RUN;
                        w_edit_nxt  = '0;
                        w_field_nxt = FLD_HH;
                    end
                end else if (w_e_next) begin
                    if (r_state == ST_SET_ALARM)
                        w_field_nxt = (r_field == FLD_HH) ? FLD_MM : FLD_HH;
                    else begin
                        case (r_field)
                            FLD_HH:  w_field_nxt = FLD_MM;
                            FLD_MM:  w_field_nxt = FLD_SS;
                            default: w_field_nxt = FLD_HH;
                        endcase
                    end
                end else if (w_e_inc) begin
                    case (r_field)
                        FLD_HH:  w_edit_nxt[23:16] = w_inc_val;
                        FLD_MM:  w_edit_nxt[15:8]  = w_inc_val;
                        default: w_edit_nxt[7:0]   = w_inc_val;
                    endcase
                end else if (w_idle_inc == TO_MAX) begin
                    w_state_nxt = ST_RUN;
                    w_edit_nxt  = '0;
                    w_field_nxt = FLD_HH;
                end else begin
                    w_idle_nxt = w_idle_inc;
                end
            end
        endcase

        if (w_state_nxt == ST_RUN) begin
            w_blink_nxt = 1'b0;
            w_bcnt_nxt  = '0;
        end else if (w_enter_set) begin
            w_blink_nxt = 1'b1;
            w_bcnt_nxt  = '0;
        end else if (r_bcnt == BL_LAST) begin
            w_blink_nxt = ~r_blink;
            w_bcnt_nxt  = '0;
        end else begin
            w_bcnt_nxt  = r_bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_prev      <= '1;
            r_setampm   <= 1'b0;
            r_edit      <= '0;
            r_field     <= FLD_HH;
            r_time_load <= 1'b0;
            r_alarm     <= '0;
            r_alarm_en  <= 1'b0;
            r_blink     <= 1'b0;
            r_bcnt      <= '0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= {btn_mode, btn_next, btn_inc, btn_fmt, btn_alen};
            r_setampm   <= w_setampm_nxt;
            r_edit      <= w_edit_nxt;
            r_field     <= w_field_nxt;
            r_time_load <= w_tload_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_en  <= w_alen_nxt;
            r_blink     <= w_blink_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    assign clk_mode   = (r_state == ST_RUN)       ? MODE_RUN :
                        (r_state == ST_SET_ALARM) ? MODE_SET_ALARM : MODE_SET_TIME;
    assign setampm    = r_setampm;
    assign edit_time  = r_edit;
    assign field_sel  = r_field;
    assign time_load  = r_time_load;
    assign alarm_time = r_alarm;
    assign alarm_en   = r_alarm_en;
    assign blink      = r_blink;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus randomized button traffic
// checked every cycle against a decimal-arithmetic behavioural model.
module tb_clock_mode_ctrl;

    localparam int BD = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_next, btn_inc, btn_fmt, btn_alen;
    logic [23:0] clock_time;
    logic [1:0]  clk_mode;
    logic        setampm;
    logic [23:0] edit_time;
    logic [1:0]  field_sel;
    logic        time_load;
    logic [23:0] alarm_time;
    logic        alarm_en;
    logic        blink;

    always #5 clk = ~clk;

    clock_mode_ctrl #(.BLINK_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_next   (btn_next),
        .btn_inc    (btn_inc),
        .btn_fmt    (btn_fmt),
        .btn_alen   (btn_alen),
        .clock_time (clock_time),
        .clk_mode   (clk_mode),
        .setampm    (setampm),
        .edit_time  (edit_time),
        .field_sel  (field_sel),
        .time_load  (time_load),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .blink      (blink)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 RUN, 1 SET_TIME, 2 SET_ALARM; m_tload marks the load cycle
    int         m_mode, m_field, m_age, m_idle;
    bit         m_tload, m_alen, m_fmt;
    logic [7:0] m_hh, m_mm, m_ss;
    logic [23:0] m_alarm;
    bit [4:0]   m_prev;

    function automatic logic [7:0] to_bcd(input int d);
        return 8'(((d / 10) << 4) | (d % 10));
    endfunction

    function automatic logic [7:0] bump(input logic [7:0] v, input int lim);
        int hi, lo, d;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9) return 8'h00;
        d = hi * 10 + lo + 1;
        if (d >= lim) return 8'h00;
        return to_bcd(d);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_age = 0; m_idle = 0;
        m_tload = 0; m_alen = 0; m_fmt = 0;
        m_hh = 0; m_mm = 0; m_ss = 0; m_alarm = 0;
        m_prev = '1;
    endtask

    task automatic model_step();
        bit em, en, ei, ef, ea;
        if (rst) begin
            model_reset();
            return;
        end
        em = btn_mode & ~m_prev[4];
        en = btn_next & ~m_prev[3];
        ei = btn_inc  & ~m_prev[2];
        ef = btn_fmt  & ~m_prev[1];
        ea = btn_alen & ~m_prev[0];
        m_prev = {btn_mode, btn_next, btn_inc, btn_fmt, btn_alen};
        if (ef) m_fmt = !m_fmt;
        if (m_tload) begin
            m_tload = 0;
            m_mode  = 2;
            {m_hh, m_mm, m_ss} = m_alarm;
            m_field = 0; m_idle = 0; m_age = 0;
        end else if (m_mode == 0) begin
            if (ea) m_alen = !m_alen;
            if (em) begin
                m_mode = 1;
                {m_hh, m_mm, m_ss} = clock_time;
                m_field = 0; m_idle = 0; m_age = 0;
            end
        end else begin
            m_age++;
            if (em || en || ei) m_idle = 0;
            if (em) begin
                if (m_mode == 1) m_tload = 1;
                else begin
                    m_alarm = {m_hh, m_mm, 8'h00};
                    m_mode  = 0;
                end
            end else if (en) begin
                m_field = (m_mode == 1) ? (m_field + 1) % 3 : 1 - m_field;
            end else if (ei) begin
                case (m_field)
                    0: m_hh = bump(m_hh, 24);
                    1: m_mm = bump(m_mm, 60);
                    default: m_ss = bump(m_ss, 60);
                endcase
            end else if (m_idle + 1 == TO) begin
                m_mode = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic check_outputs();
        bit run;
        run = (m_mode == 0);
        check_val("clk_mode",   32'(clk_mode),   32'(m_mode));
        check_val("setampm",    32'(setampm),    32'(m_fmt));
        check_val("edit_time",  32'(edit_time),  run ? 32'd0 : 32'({m_hh, m_mm, m_ss}));
        check_val("field_sel",  32'(field_sel),  run ? 32'd0 : 32'(m_field));
        check_val("time_load",  32'(time_load),  32'(m_tload));
        check_val("alarm_time", 32'(alarm_time), 32'(m_alarm));
        check_val("alarm_en",   32'(alarm_en),   32'(m_alen));
        check_val("blink",      32'(blink),      run ? 32'd0 : 32'(((m_age / BD) % 2) == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic press(input int which);
        case (which)
            0: btn_mode = 1'b1;
            1: btn_next = 1'b1;
            2: btn_inc  = 1'b1;
            3: btn_fmt  = 1'b1;
            default: btn_alen = 1'b1;
        endcase
        tick();
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_fmt = 1'b0; btn_alen = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b1; btn_next = 1'b0; btn_inc = 1'b0; btn_fmt = 1'b0; btn_alen = 1'b0;
        clock_time = 24'h000000;
        repeat (3) tick();
        check_val("rst_clk_mode", 32'(clk_mode), 32'd0);
        check_val("rst_alarm", 32'(alarm_time), 32'd0);
        check_val("rst_blink", 32'(blink), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check_val("held_mode_no_fire", 32'(clk_mode), 32'd0);
        btn_mode = 1'b0;
        tick();

        // Set-time editing walk
        clock_time = 24'h235958;
        press(0);
        check_val("enter_capture", 32'(edit_time), 32'h235958);
        press(2);
        check_val("inc_hh_wrap", 32'(edit_time), 32'h005958);
        press(1); press(2);
        check_val("inc_mm_wrap", 32'(edit_time), 32'h000058);
        press(1); press(2);
        check_val("inc_ss", 32'(edit_time), 32'h000059);
        btn_mode = 1'b1;
        tick();
        check_val("load_strobe", 32'(time_load), 32'd1);
        check_val("load_edit", 32'(edit_time), 32'h000059);
        check_val("load_mode", 32'(clk_mode), 32'd1);
        btn_mode = 1'b0;
        tick();
        check_val("load_one_cycle", 32'(time_load), 32'd0);
        check_val("alarm_mode", 32'(clk_mode), 32'd2);

        // Alarm setting
        repeat (7) press(2);
        press(1);
        repeat (30) press(2);
        press(0);
        check_val("alarm_stored", 32'(alarm_time), 32'h073000);
        check_val("back_run", 32'(clk_mode), 32'd0);
        press(4);
        check_val("alarm_en_on", 32'(alarm_en), 32'd1);

        // Simultaneous mode/next/inc: mode wins
        clock_time = 24'h123456;
        press(0);
        btn_mode = 1'b1; btn_next = 1'b1; btn_inc = 1'b1;
        tick();
        check_val("prio_load", 32'(time_load), 32'd1);
        check_val("prio_field", 32'(field_sel), 32'd0);
        check_val("prio_edit", 32'(edit_time), 32'h123456);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        tick();
        press(3);
        check_val("fmt_toggle", 32'(setampm), 32'd1);
        press(0);

        // Idle timeout and blink cadence
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check_val("to_mode", 32'(clk_mode), (i < TO) ? 32'd1 : 32'd0);
            check_val("to_blink", 32'(blink), (i < TO) ? 32'(((i / BD) % 2) == 0) : 32'd0);
            check_val("to_no_load", 32'(time_load), 32'd0);
        end

        // Randomized traffic: busy bursts separated by quiet gaps
        for (int seg = 0; seg < 60; seg++) begin
            for (int c = 0; c < 40; c++) begin
                btn_mode = btn_mode ^ ($urandom_range(0, 7) == 0);
                btn_next = btn_next ^ ($urandom_range(0, 4) == 0);
                btn_inc  = btn_inc  ^ ($urandom_range(0, 2) == 0);
                btn_fmt  = btn_fmt  ^ ($urandom_range(0, 9) == 0);
                btn_alen = btn_alen ^ ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        clock_time = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                                      to_bcd($urandom_range(0, 59))};
                    else
                        clock_time = 24'($urandom);
                end
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
            rst = 1'b0;
            btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
            repeat ($urandom_range(2, 30)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
